// File: rtl/fsm_stim_driver_pkg.sv
// Shared types and helpers for the fsm stimulus driver: run-state encoding and
// the half-period clamp used by each toggle channel.
package fsm_stim_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // A half-period of zero would never reload; treat it as one cycle.
  function automatic int unsigned clamp_half(input int unsigned h);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/fsm_stim_driver_toggle_chan.sv
// One square-wave channel: latches its half-period on load, then toggles q
// every half cycles while enabled; q is forced low on load and when disabled.
module toggle_chan
  import fsm_stim_driver_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] half,
  output logic         q
);

  logic [W-1:0] half_q;
  logic [W-1:0] cnt_q;
  logic         q_q;

  // cnt_q tracks k mod half so q_q equals (k / half) mod 2 at RUN cycle k.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q <= '0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
    end else if (load) begin
      half_q <= W'(clamp_half(32'(half)));
      cnt_q  <= '0;
      q_q    <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      q_q    <= 1'b0;
    end else if (cnt_q == half_q - W'(1)) begin
      cnt_q  <= '0;
      q_q    <= ~q_q;
    end else begin
      cnt_q  <= cnt_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fsm_stim_driver.sv
// Stimulus driver for the fsm block: drives in0/in1 square waves for a
// programmed number of cycles, then counts rising edges on the returned out.
module fsm_stim_driver
  import fsm_stim_driver_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned EDGE_W    = 16,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  half0,
  input  logic [CNT_W-1:0]  half1,
  input  logic [LEN_W-1:0]  len,
  output logic              in0,
  output logic              in1,
  input  logic              out,
  output logic              busy,
  output logic              done,
  output logic [EDGE_W-1:0] edges
);

  localparam int unsigned DRN_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  state_e            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DRN_W-1:0]  drn_q;
  logic              out_q;
  logic              busy_q;
  logic              done_q;
  logic [EDGE_W-1:0] edges_q;

  logic              load_c;
  logic              last_run_c;
  logic              chan_en_c;
  logic              rise_c;

  assign load_c     = (state_q == ST_IDLE) && start && !abort;
  assign last_run_c = (rem_q == LEN_W'(1));
  // Channels advance only while the next cycle is still a RUN cycle.
  assign chan_en_c  = (state_q == ST_RUN) && !abort && !last_run_c;
  assign rise_c     = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && out && !out_q;

  toggle_chan #(.W(CNT_W)) u_chan0 (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .en   (chan_en_c),
    .half (half0),
    .q    (in0)
  );

  toggle_chan #(.W(CNT_W)) u_chan1 (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .en   (chan_en_c),
    .half (half1),
    .q    (in1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      drn_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      edges_q <= '0;
    end else begin
      out_q  <= out;
      done_q <= 1'b0;
      if (rise_c && (edges_q != '1)) begin
        edges_q <= edges_q + EDGE_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (load_c) begin
            edges_q <= '0;
            rem_q   <= len;
            if (len != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else if (DRAIN_CYC != 0) begin
              state_q <= ST_DRAIN;
              drn_q   <= DRN_W'(DRAIN_CYC);
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (last_run_c) begin
            if (DRAIN_CYC != 0) begin
              state_q <= ST_DRAIN;
              drn_q   <= DRN_W'(DRAIN_CYC);
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            rem_q <= rem_q - LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (drn_q == DRN_W'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drn_q <= drn_q - DRN_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign edges = edges_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Directed bench for fsm_stim_driver: out is looped back from in0, in1 or a
// bench-forced level, and each step compares outputs against hand-derived values.
module tb_fsm_stim_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  half0;
  logic [7:0]  half1;
  logic [15:0] len;
  logic        in0;
  logic        in1;
  logic        out_w;
  logic        busy;
  logic        done;
  logic [15:0] edges;

  logic [1:0]  out_sel;
  logic        out_force;

  int vectors     = 0;
  int miscompares = 0;
  int n;
  int done_seen;

  always #5 clk = ~clk;

  assign out_w = (out_sel == 2'd0) ? in0 : (out_sel == 2'd1) ? in1 : out_force;

  fsm_stim_driver #(
    .CNT_W(8), .LEN_W(16), .EDGE_W(16), .DRAIN_CYC(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .half0 (half0),
    .half1 (half1),
    .len   (len),
    .in0   (in0),
    .in1   (in1),
    .out   (out_w),
    .busy  (busy),
    .done  (done),
    .edges (edges)
  );

  task automatic tick(input int cnt = 1);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents start for one edge; afterwards the bench sits in RUN cycle k=0.
  task automatic start_run(input logic [7:0] h0, input logic [7:0] h1, input logic [15:0] l);
    half0 = h0;
    half1 = h1;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles until done is seen; the bound keeps a missing done from hanging.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    half0 = 8'd5; half1 = 8'd5; len = 16'd10;
    out_sel = 2'd0; out_force = 1'b0;
    tick(3);
    chk("rst_in0",   32'(in0),   32'd0);
    chk("rst_in1",   32'(in1),   32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_edges", 32'(edges), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // in0 rises at k=13,39,65,91; done at T+105 i.e. 104 ticks after k=0.
    out_sel = 2'd0;
    start_run(8'd13, 8'd17, 16'd100);
    chk("a_busy_k0", 32'(busy), 32'd1);
    chk("a_in0_k0",  32'(in0),  32'd0);
    tick(13);
    chk("a_in0_k13", 32'(in0),  32'd1);
    wait_done(n);
    chk("a_done_lat", 32'(n), 32'd91);
    chk("a_edges",    32'(edges), 32'd4);
    tick();
    chk("a_busy_after", 32'(busy), 32'd0);
    chk("a_done_pulse", 32'(done), 32'd0);

    // in1 rises at k=17,51,85; a start at k=17 must not disturb the run.
    out_sel = 2'd1;
    start_run(8'd13, 8'd17, 16'd100);
    tick(17);
    chk("b_in1_k17", 32'(in1), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("b_done_lat", 32'(n), 32'd86);
    chk("b_edges",    32'(edges), 32'd3);
    tick();

    // Zero-length run: straight to DRAIN for 4 cycles, done at T+5.
    out_sel = 2'd0;
    start_run(8'd3, 8'd3, 16'd0);
    chk("z_busy", 32'(busy), 32'd1);
    chk("z_in0",  32'(in0),  32'd0);
    wait_done(n);
    chk("z_done_lat", 32'(n), 32'd4);
    chk("z_edges",    32'(edges), 32'd0);
    tick();

    // Half-period 0 clamps to 1: in0 = k mod 2, four rises in 8 cycles.
    start_run(8'd0, 8'd2, 16'd8);
    chk("c_in0_k0", 32'(in0), 32'd0);
    tick();
    chk("c_in0_k1", 32'(in0), 32'd1);
    chk("c_in1_k1", 32'(in1), 32'd0);
    wait_done(n);
    chk("c_done_lat", 32'(n), 32'd11);
    chk("c_edges",    32'(edges), 32'd4);
    tick();

    // Abort at k=20: outputs drop next cycle, no done, partial count kept.
    start_run(8'd13, 8'd17, 16'd100);
    tick(20);
    chk("d_in1_k20", 32'(in1), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("d_in0",  32'(in0),  32'd0);
    chk("d_in1",  32'(in1),  32'd0);
    chk("d_busy", 32'(busy), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 110; i++) begin
      if (done) done_seen++;
      tick();
    end
    chk("d_no_done", 32'(done_seen), 32'd0);
    chk("d_edges",   32'(edges), 32'd1);

    // start with abort in IDLE is suppressed; edges is not cleared.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("e_busy",  32'(busy),  32'd0);
    tick();
    chk("e_busy2", 32'(busy),  32'd0);
    chk("e_edges", 32'(edges), 32'd1);

    // out held high across start is not an edge; a later 0->1 at k=5 is.
    out_sel = 2'd2; out_force = 1'b1;
    tick(2);
    start_run(8'd13, 8'd13, 16'd10);
    tick(3);
    out_force = 1'b0;
    tick(2);
    out_force = 1'b1;
    chk("f_edges_k5", 32'(edges), 32'd0);
    wait_done(n);
    chk("f_done_lat", 32'(n), 32'd9);
    chk("f_edges",    32'(edges), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
